// File: rtl/ddr3_avalon_arbiter.sv
// Two-master arbiter for a single Avalon-MM DDR3 port, with read-tag FIFO for return routing.
// Define DDR3_ARB_FIXED_PRIO_EN for fixed priority (m0 wins); default is round-robin.
module ddr3_avalon_arbiter #(
  parameter int unsigned ADDR_W          = 29,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned BURST_W         = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  systemClock,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [BURST_W-1:0]    m0_burstcount,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [BURST_W-1:0]    m1_burstcount,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     address,
  output logic [BURST_W-1:0]    burstcount,
  output logic                  read,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  output logic [DATA_W/8-1:0]   byteenable,
  input  logic                  waitrequest,
  input  logic [DATA_W-1:0]     readdata,
  input  logic                  readdatavalid,
  output logic                  err_rdv
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam logic [PTR_W:0] FifoDepth = (PTR_W+1)'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StCmd, StWburst} state_e;

  state_e               r_state;
  logic                 r_owner;
  logic [BURST_W-1:0]   r_beats_left;
`ifndef DDR3_ARB_FIXED_PRIO_EN
  logic                 r_last;
`endif

  logic                 r_fifo_id    [MAX_OUTSTANDING];
  logic [BURST_W-1:0]   r_fifo_beats [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]       r_count;
  logic                 r_err_rdv;

  logic                 w_full, w_empty, w_req0, w_req1, w_grant;
  logic                 w_own_read, w_own_write, w_own_wait;
  logic [BURST_W-1:0]   w_own_bc_raw;
  logic                 w_accept, w_push, w_rdv_ok, w_pop, w_head_id;
  logic [BURST_W-1:0]   w_head_beats;

  assign w_full  = (r_count == FifoDepth);
  assign w_empty = (r_count == '0);
  assign w_req0  = m0_write | (m0_read & ~w_full);
  assign w_req1  = m1_write | (m1_read & ~w_full);

`ifdef DDR3_ARB_FIXED_PRIO_EN
  assign w_grant = ~w_req0;
`else
  assign w_grant = (w_req0 & w_req1) ? ~r_last : w_req1;
`endif

  assign w_own_read   = r_owner ? m1_read       : m0_read;
  assign w_own_write  = r_owner ? m1_write      : m0_write;
  assign w_own_bc_raw = r_owner ? m1_burstcount : m0_burstcount;

  always_comb begin
    address    = '0;
    burstcount = '0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    byteenable = '0;
    w_own_wait = 1'b1;
    if (r_state != StIdle) begin
      address    = r_owner ? m1_address    : m0_address;
      burstcount = (w_own_bc_raw == '0) ? BURST_W'(1) : w_own_bc_raw;
      writedata  = r_owner ? m1_writedata  : m0_writedata;
      byteenable = r_owner ? m1_byteenable : m0_byteenable;
      write      = w_own_write;
      // Reads only start a command; inside a write burst they wait for IDLE.
      read       = (r_state == StCmd) & w_own_read & ~w_own_write & ~w_full;
      w_own_wait = (read | write) ? waitrequest : 1'b1;
    end
  end

  assign m0_waitrequest = (r_state != StIdle && !r_owner) ? w_own_wait : 1'b1;
  assign m1_waitrequest = (r_state != StIdle &&  r_owner) ? w_own_wait : 1'b1;

  assign w_accept = (read | write) & ~waitrequest;
  assign w_push   = (r_state == StCmd) & read & ~waitrequest;

  always_ff @(posedge systemClock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_beats_left <= '0;
`ifndef DDR3_ARB_FIXED_PRIO_EN
      r_last       <= 1'b1;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_req0 | w_req1) begin
            r_owner <= w_grant;
`ifndef DDR3_ARB_FIXED_PRIO_EN
            r_last  <= w_grant;
`endif
            r_state <= StCmd;
          end
        end
        StCmd: begin
          if (w_accept) begin
            if (write && burstcount > BURST_W'(1)) begin
              r_beats_left <= burstcount - BURST_W'(1);
              r_state      <= StWburst;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        StWburst: begin
          if (w_accept) begin
            r_beats_left <= r_beats_left - BURST_W'(1);
            if (r_beats_left == BURST_W'(1)) r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_head_id        = r_fifo_id[r_rd_ptr];
  assign w_head_beats     = r_fifo_beats[r_rd_ptr];
  assign w_rdv_ok         = readdatavalid & ~w_empty;
  assign w_pop            = w_rdv_ok & (w_head_beats == BURST_W'(1));
  assign m0_readdatavalid = w_rdv_ok & ~w_head_id;
  assign m1_readdatavalid = w_rdv_ok &  w_head_id;
  assign m0_readdata      = readdata;
  assign m1_readdata      = readdata;
  assign err_rdv          = r_err_rdv;

  // Push slot never aliases the head while the FIFO is non-empty and not full.
  always_ff @(posedge systemClock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        r_fifo_id[i]    <= 1'b0;
        r_fifo_beats[i] <= '0;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_rdv <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_id[r_wr_ptr]    <= r_owner;
        r_fifo_beats[r_wr_ptr] <= burstcount;
        r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
      end
      if (readdatavalid && w_empty) r_err_rdv <= 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else if (w_rdv_ok) begin
        r_fifo_beats[r_rd_ptr] <= w_head_beats - BURST_W'(1);
      end
      r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
    end
  end

endmodule
